// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared owner encoding and counter width for the memory port arbiter
package arb_pkg;

  localparam int STARVE_CNT_W = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LS   = 2'd2
  } owner_e;

endpackage

// File: rtl/arb_starve_counter.sv
// rtl/arb_starve_counter.sv - saturating count of consecutive cycles fetch lost arbitration
module arb_starve_counter
  import arb_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    inc,
  input  logic                    clr,
  input  logic [STARVE_CNT_W-1:0] limit,
  output logic                    at_limit
);

  logic [STARVE_CNT_W-1:0] cnt_q;
  logic [STARVE_CNT_W-1:0] cnt_d;

  // clear wins over increment; the count stops once it reaches the limit
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q < limit)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_limit = (cnt_q == limit);

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one sync-read memory port between fetch and load/store; optional ARB_PERF_CNT_EN
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_valid_o,
  output logic              if_stall_o,
  input  logic              ls_req_i,
  input  logic              ls_we_i,
  input  logic [ADDR_W-1:0] ls_addr_i,
  input  logic [DATA_W-1:0] ls_wdata_i,
  output logic [DATA_W-1:0] ls_rdata_o,
  output logic              ls_valid_o,
  output logic              ls_stall_o,
`ifdef ARB_PERF_CNT_EN
  output logic [31:0]       perf_conflict_o,
  output logic [31:0]       perf_force_o,
`endif
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

  logic   at_limit;
  logic   grant_if;
  logic   grant_ls;
  owner_e owner_q;
  owner_e owner_d;
  logic   store_q;
  logic   store_d;

  // load/store wins conflicts unless fetch has starved for LIMIT cycles
  always_comb begin
    grant_if = if_req_i & (~ls_req_i | at_limit);
    grant_ls = ls_req_i & ~grant_if;
  end

  assign if_stall_o = if_req_i & ~grant_if;
  assign ls_stall_o = ls_req_i & ~grant_ls;

  // drive the memory port from the winner; fetch never writes
  always_comb begin
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (grant_ls) begin
      mem_en_o    = 1'b1;
      mem_we_o    = ls_we_i;
      mem_addr_o  = ls_addr_i;
      mem_wdata_o = ls_wdata_i;
    end else if (grant_if) begin
      mem_en_o    = 1'b1;
      mem_addr_o  = if_addr_i;
    end
  end

  // remember who owns next cycle's read data, and whether it was a store
  always_comb begin
    owner_d = OWN_NONE;
    store_d = 1'b0;
    if (grant_if) begin
      owner_d = OWN_IF;
    end else if (grant_ls) begin
      owner_d = OWN_LS;
      store_d = ls_we_i;
    end
  end

  // owner register; reset drops any access in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q <= OWN_NONE;
      store_q <= 1'b0;
    end else begin
      owner_q <= owner_d;
      store_q <= store_d;
    end
  end

  // route memory read data to the owner only; stores complete with zero data
  always_comb begin
    if_valid_o = (owner_q == OWN_IF);
    ls_valid_o = (owner_q == OWN_LS);
    if_rdata_o = if_valid_o ? mem_rdata_i : '0;
    ls_rdata_o = (ls_valid_o && !store_q) ? mem_rdata_i : '0;
  end

  arb_starve_counter u_starve (
    .clk      (clk),
    .rst      (rst),
    .inc      (if_req_i & grant_ls),
    .clr      (grant_if | ~if_req_i),
    .limit    (LIMIT),
    .at_limit (at_limit)
  );

`ifdef ARB_PERF_CNT_EN
  logic [31:0] conflict_q;
  logic [31:0] conflict_d;
  logic [31:0] force_q;
  logic [31:0] force_d;

  // count conflict cycles and starvation-forced fetch grants, wrapping naturally
  always_comb begin
    conflict_d = conflict_q;
    force_d    = force_q;
    if (if_req_i && ls_req_i) begin
      conflict_d = conflict_q + 32'd1;
      if (at_limit) begin
        force_d = force_q + 32'd1;
      end
    end
  end

  // performance counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_q <= '0;
      force_q    <= '0;
    end else begin
      conflict_q <= conflict_d;
      force_q    <= force_d;
    end
  end

  assign perf_conflict_o = conflict_q;
  assign perf_force_o    = force_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter; ARB_PERF_CNT_EN enables counter checks
module tb_mem_port_arbiter;

  localparam int AW  = 16;
  localparam int DW  = 32;
  localparam int LIM = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_valid;
  logic          if_stall;
  logic          ls_req;
  logic          ls_we;
  logic [AW-1:0] ls_addr;
  logic [DW-1:0] ls_wdata;
  logic [DW-1:0] ls_rdata;
  logic          ls_valid;
  logic          ls_stall;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
`ifdef ARB_PERF_CNT_EN
  logic [31:0]   perf_conflict;
  logic [31:0]   perf_force;
`endif

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W       (AW),
    .DATA_W       (DW),
    .STARVE_LIMIT (LIM)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .if_req_i        (if_req),
    .if_addr_i       (if_addr),
    .if_rdata_o      (if_rdata),
    .if_valid_o      (if_valid),
    .if_stall_o      (if_stall),
    .ls_req_i        (ls_req),
    .ls_we_i         (ls_we),
    .ls_addr_i       (ls_addr),
    .ls_wdata_i      (ls_wdata),
    .ls_rdata_o      (ls_rdata),
    .ls_valid_o      (ls_valid),
    .ls_stall_o      (ls_stall),
`ifdef ARB_PERF_CNT_EN
    .perf_conflict_o (perf_conflict),
    .perf_force_o    (perf_force),
`endif
    .mem_en_o        (mem_en),
    .mem_we_o        (mem_we),
    .mem_addr_o      (mem_addr),
    .mem_wdata_o     (mem_wdata),
    .mem_rdata_i     (mem_rdata)
  );

  // synchronous-read memory; non-read cycles return junk so leaks are visible
  logic [DW-1:0] mem [0:65535];

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = {16'hA5A5, a[15:0]};
    mem[0] = 32'h11;
    mem[1] = 32'h22;
    mem[2] = 32'h33;
  end

  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      mem[mem_addr] <= mem_wdata;
      mem_rdata     <= 32'hBADC0FFE;
    end else if (mem_en) begin
      mem_rdata     <= mem[mem_addr];
    end else begin
      mem_rdata     <= 32'hBADC0FFE;
    end
  end

  typedef struct packed {
    logic [1:0]    own;
    logic [DW-1:0] data;
  } rsp_t;

  rsp_t sb_q[$];
  int   n_chk        = 0;
  int   n_pass       = 0;
  int   model_starve = 0;
  int   obs_if_cnt   = 0;
  logic last_if_stall;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // one issue cycle: check grant-side outputs, push expected response, then check it
  task automatic tick();
    logic gif;
    logic gls;
    rsp_t r;
    rsp_t e;
    #2;
    gif = if_req & (!ls_req | (model_starve == LIM));
    gls = ls_req & !gif;
    last_if_stall = if_stall;
    chk("if_stall", if_stall, if_req & !gif);
    chk("ls_stall", ls_stall, ls_req & !gls);
    chk("mem_en", mem_en, gif | gls);
    chk("mem_we", mem_we, gls & ls_we);
    if (gif) chk("mem_addr_if", mem_addr, if_addr);
    if (gls) chk("mem_addr_ls", mem_addr, ls_addr);
    if (gls && ls_we) chk("mem_wdata", mem_wdata, ls_wdata);
    r.own  = gif ? 2'd1 : (gls ? 2'd2 : 2'd0);
    r.data = gif ? mem[if_addr] : ((gls && !ls_we) ? mem[ls_addr] : '0);
    sb_q.push_back(r);
    if (gif || !if_req) model_starve = 0;
    else if (gls && model_starve < LIM) model_starve++;
    @(posedge clk);
    #1;
    if (if_valid) obs_if_cnt++;
    if (sb_q.size() == 0) begin
      chk("sb_empty", 1, 0);
    end else begin
      e = sb_q.pop_front();
      chk("if_valid", if_valid, e.own == 2'd1);
      chk("ls_valid", ls_valid, e.own == 2'd2);
      chk("if_rdata", if_rdata, (e.own == 2'd1) ? e.data : '0);
      chk("ls_rdata", ls_rdata, (e.own == 2'd2) ? e.data : '0);
    end
  endtask

  task automatic clear_model();
    sb_q.delete();
    model_starve = 0;
  endtask

  logic [7:0] stall_rec;

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; if_req = 1'b0; if_addr = '0;
    ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_if_valid", if_valid, 0);
    chk("rst_ls_valid", ls_valid, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_if_stall", if_stall, 0);
    chk("rst_ls_stall", ls_stall, 0);
    rst = 1'b0;

    // fetch-only reads
    for (int i = 0; i < 3; i++) begin
      if_req = 1'b1; if_addr = AW'(i);
      tick();
      chk("t1_if_data", if_rdata, 32'h11 * (i + 1));
    end
    if_req = 1'b0;

    // sustained conflict: LS,LS,LS,IF repeating
    if_req = 1'b1; if_addr = 16'h0010;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 16'h0100;
    for (int i = 0; i < 8; i++) begin
      tick();
      stall_rec[i] = last_if_stall;
    end
    chk("t2_stall_pattern", stall_rec, 8'b0111_0111);
    if_req = 1'b0; ls_req = 1'b0;
    tick();

    // store, then load it back
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 16'h0040; ls_wdata = 32'hDEADBEEF;
    tick();
    chk("t3_store_valid", ls_valid, 1);
    chk("t3_store_rdata", ls_rdata, 0);
    ls_we = 1'b0;
    tick();
    chk("t3_readback", ls_rdata, 32'hDEADBEEF);
    ls_req = 1'b0;
    tick();

    // reset in the response cycle of a fetch
    if_req = 1'b1; if_addr = 16'h0001;
    tick();
    rst = 1'b1; if_req = 1'b0;
    @(posedge clk); #1;
    chk("t4_if_valid_after_rst", if_valid, 0);
    chk("t4_ls_valid_after_rst", ls_valid, 0);
    rst = 1'b0; clear_model();

    // reset during the grant cycle drops the access
    if_req = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    chk("t4_drop_if_valid", if_valid, 0);
    rst = 1'b0; if_req = 1'b0; clear_model();

    // reset clears a partially built starvation count
    if_req = 1'b1; ls_req = 1'b1; ls_addr = 16'h0100;
    tick(); tick();
    rst = 1'b1;
    @(posedge clk); #1;
    chk("t4_valid_during_rst", if_valid | ls_valid, 0);
    rst = 1'b0; clear_model();
    for (int i = 0; i < 4; i++) begin
      tick();
      stall_rec[i] = last_if_stall;
    end
    chk("t4_starve_cleared", stall_rec[3:0], 4'b0111);
    if_req = 1'b0; ls_req = 1'b0;
    tick();

    // fetch alternating with idle never starves long enough to win
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 16'h0100; if_addr = 16'h0002;
    obs_if_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if_req = (i % 2 == 0);
      tick();
    end
    chk("t5_if_grants", obs_if_cnt, 0);
    ls_req = 1'b0; if_req = 1'b1;
    tick();
    chk("t5_if_after_ls_drop", if_valid, 1);
    if_req = 1'b0;
    tick();

`ifdef ARB_PERF_CNT_EN
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; clear_model();
    if_req = 1'b1; ls_req = 1'b1; ls_we = 1'b0; ls_addr = 16'h0100; if_addr = 16'h0003;
    for (int i = 0; i < 10; i++) tick();
    chk("perf_conflict", perf_conflict, 32'd10);
    chk("perf_force", perf_force, 32'd2);
    if_req = 1'b0; ls_req = 1'b0;
    tick();
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
